// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - arbiter sharing one memory port between fetch (IFU) and load/store (LSU)
// Optional feature: define MEM_ARB_RR_EN for round-robin priority (default: LSU over IFU).
module mem_arb #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            ifu_reqValid,
   input  logic [AW-1:0]   ifu_addr,
   output logic            ifu_respValid,
   input  logic            lsu_reqValid,
   input  logic            lsu_wen,
   input  logic [AW-1:0]   lsu_addr,
   input  logic [DW-1:0]   lsu_wdata,
   input  logic [DW/8-1:0] lsu_wmask,
   output logic            lsu_respValid,
   output logic [DW-1:0]   rdata,
   output logic            mem_reqValid,
   output logic            mem_wen,
   output logic [AW-1:0]   mem_addr,
   output logic [DW-1:0]   mem_wdata,
   output logic [DW/8-1:0] mem_wmask,
   input  logic            mem_respValid,
   input  logic [DW-1:0]   mem_rdata
);

   typedef enum logic {IDLE, BUSY} state_t;
   typedef enum logic {OWN_IFU, OWN_LSU} owner_t;

   state_t state, state_nxt;
   owner_t owner, owner_nxt;

   logic            ifu_pend;
   logic [AW-1:0]   ifu_pend_addr;
   logic            lsu_pend;
   logic            lsu_pend_wen;
   logic [AW-1:0]   lsu_pend_addr;
   logic [DW-1:0]   lsu_pend_wdata;
   logic [DW/8-1:0] lsu_pend_wmask;

   logic ifu_drop, lsu_drop, ifu_cand, lsu_cand, grant_ifu, grant_lsu;

   assign rdata = mem_rdata;

   // A request is illegal while its slot is full or its own transaction is outstanding.
   assign ifu_drop = ifu_reqValid && (ifu_pend || (state == BUSY && owner == OWN_IFU));
   assign lsu_drop = lsu_reqValid && (lsu_pend || (state == BUSY && owner == OWN_LSU));
   assign ifu_cand = (state == IDLE) && !reset && (ifu_pend || ifu_reqValid);
   assign lsu_cand = (state == IDLE) && !reset && (lsu_pend || lsu_reqValid);

`ifdef MEM_ARB_RR_EN
   owner_t rr_last;

   // rr_last holds the most recent grantee; the other requester wins a tie.
   assign grant_lsu = lsu_cand && (!ifu_cand || rr_last == OWN_IFU);
   assign grant_ifu = ifu_cand && !grant_lsu;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         rr_last <= OWN_IFU;
      else if (grant_lsu)
         rr_last <= OWN_LSU;
      else if (grant_ifu)
         rr_last <= OWN_IFU;
   end
`else
   assign grant_lsu = lsu_cand;
   assign grant_ifu = ifu_cand && !lsu_cand;
`endif

   always_comb begin
      state_nxt     = state;
      owner_nxt     = owner;
      mem_reqValid  = 1'b0;
      mem_wen       = 1'b0;
      mem_addr      = '0;
      mem_wdata     = '0;
      mem_wmask     = '0;
      ifu_respValid = 1'b0;
      lsu_respValid = 1'b0;
      case (state)
         IDLE: begin
            if (grant_lsu) begin
               mem_reqValid = 1'b1;
               mem_wen      = lsu_pend ? lsu_pend_wen   : lsu_wen;
               mem_addr     = lsu_pend ? lsu_pend_addr  : lsu_addr;
               mem_wdata    = lsu_pend ? lsu_pend_wdata : lsu_wdata;
               mem_wmask    = lsu_pend ? lsu_pend_wmask : lsu_wmask;
               state_nxt    = BUSY;
               owner_nxt    = OWN_LSU;
            end else if (grant_ifu) begin
               mem_reqValid = 1'b1;
               mem_addr     = ifu_pend ? ifu_pend_addr : ifu_addr;
               state_nxt    = BUSY;
               owner_nxt    = OWN_IFU;
            end
         end
         BUSY: begin
            if (mem_respValid) begin
               state_nxt = IDLE;
               if (owner == OWN_LSU)
                  lsu_respValid = 1'b1;
               else
                  ifu_respValid = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         owner <= OWN_IFU;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ifu_pend       <= 1'b0;
         ifu_pend_addr  <= '0;
         lsu_pend       <= 1'b0;
         lsu_pend_wen   <= 1'b0;
         lsu_pend_addr  <= '0;
         lsu_pend_wdata <= '0;
         lsu_pend_wmask <= '0;
      end else begin
         if (grant_ifu) begin
            ifu_pend <= 1'b0;
         end else if (ifu_reqValid && !ifu_drop) begin
            ifu_pend      <= 1'b1;
            ifu_pend_addr <= ifu_addr;
         end
         if (grant_lsu) begin
            lsu_pend <= 1'b0;
         end else if (lsu_reqValid && !lsu_drop) begin
            lsu_pend       <= 1'b1;
            lsu_pend_wen   <= lsu_wen;
            lsu_pend_addr  <= lsu_addr;
            lsu_pend_wdata <= lsu_wdata;
            lsu_pend_wmask <= lsu_wmask;
         end
      end
   end

   ifu_req_protocol: assert property (@(posedge clock) disable iff (reset) !ifu_drop);
   lsu_req_protocol: assert property (@(posedge clock) disable iff (reset) !lsu_drop);

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - self-checking bench for mem_arb: directed scenarios plus randomized traffic vs a queue model
module tb_mem_arb;

   logic        clock = 1'b0;
   logic        reset;
   logic        ifu_reqValid;
   logic [31:0] ifu_addr;
   logic        ifu_respValid;
   logic        lsu_reqValid;
   logic        lsu_wen;
   logic [31:0] lsu_addr;
   logic [31:0] lsu_wdata;
   logic [3:0]  lsu_wmask;
   logic        lsu_respValid;
   logic [31:0] rdata;
   logic        mem_reqValid;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wmask;
   logic        mem_respValid;
   logic [31:0] mem_rdata;

   int vectors = 0;
   int miscompares = 0;

   wire [69:0] mem_bus  = {mem_reqValid, mem_wen, mem_addr, mem_wdata, mem_wmask};
   wire [1:0]  resp_bus = {ifu_respValid, lsu_respValid};

   typedef struct {
      logic        wen;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   mem_arb #(.AW(32), .DW(32)) dut (
      .clock(clock), .reset(reset),
      .ifu_reqValid(ifu_reqValid), .ifu_addr(ifu_addr), .ifu_respValid(ifu_respValid),
      .lsu_reqValid(lsu_reqValid), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
      .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_respValid(lsu_respValid),
      .rdata(rdata),
      .mem_reqValid(mem_reqValid), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
      .mem_respValid(mem_respValid), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   // Advance to the next cycle with every request/response input quiet.
   task automatic quiet_cycle();
      @(negedge clock);
      ifu_reqValid = 0; ifu_addr = 0;
      lsu_reqValid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_respValid = 0; mem_rdata = 0;
   endtask

   task automatic test_reset();
      quiet_cycle();
      reset = 1;
      #1;
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h1234; lsu_reqValid = 1; lsu_addr = 32'h55;
      mem_respValid = 1; mem_rdata = 32'hA5A5_0001;
      #1;
      vectors++;
      if (mem_bus !== 70'h0) begin miscompares++; $display("FAIL reset_mem_bus: got %h expected 0", mem_bus); end
      vectors++;
      if (resp_bus !== 2'b00) begin miscompares++; $display("FAIL reset_resp: got %b expected 00", resp_bus); end
      vectors++;
      if (rdata !== 32'hA5A5_0001) begin miscompares++; $display("FAIL reset_rdata_passthru: got %h expected a5a50001", rdata); end
      quiet_cycle();
      reset = 0;
   endtask

   task automatic test_ifu_fetch();
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h8000_0000;
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL fetch_issue: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'h0});
      end
      for (int i = 0; i < 2; i++) begin
         quiet_cycle();
         #1;
         vectors++;
         if (mem_bus !== 70'h0 || resp_bus !== 2'b00) begin
            miscompares++; $display("FAIL fetch_wait: mem %h resp %b expected 0/00", mem_bus, resp_bus);
         end
      end
      quiet_cycle();
      mem_respValid = 1; mem_rdata = 32'h0000_0013;
      #1;
      vectors++;
      if (resp_bus !== 2'b10 || rdata !== 32'h13) begin
         miscompares++; $display("FAIL fetch_resp: resp %b rdata %h expected 10/00000013", resp_bus, rdata);
      end
      quiet_cycle();
      #1;
      vectors++;
      if (resp_bus !== 2'b00) begin miscompares++; $display("FAIL fetch_resp_pulse: got %b expected 00", resp_bus); end
   endtask

   task automatic test_simultaneous();
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h100;
      lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h200; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'hF;
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF}) begin
         miscompares++; $display("FAIL simul_lsu_first: got %h expected %h", mem_bus, {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF});
      end
      quiet_cycle();
      #1;
      vectors++;
      if (mem_reqValid !== 1'b0) begin miscompares++; $display("FAIL simul_busy_hold: got %b expected 0", mem_reqValid); end
      quiet_cycle();
      mem_respValid = 1; mem_rdata = 32'h77;
      #1;
      vectors++;
      if (resp_bus !== 2'b01 || mem_reqValid !== 1'b0) begin
         miscompares++; $display("FAIL simul_lsu_resp: resp %b req %b expected 01/0", resp_bus, mem_reqValid);
      end
      quiet_cycle();
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h100, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL simul_ifu_next: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h100, 32'h0, 4'h0});
      end
      quiet_cycle();
      mem_respValid = 1;
      #1;
      vectors++;
      if (resp_bus !== 2'b10) begin miscompares++; $display("FAIL simul_ifu_resp: got %b expected 10", resp_bus); end
   endtask

   task automatic test_busy_capture();
      quiet_cycle();
      lsu_reqValid = 1; lsu_wen = 0; lsu_addr = 32'h40;
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h40, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL busy_lsu_load: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h40, 32'h0, 4'h0});
      end
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h300;
      #1;
      vectors++;
      if (mem_bus !== 70'h0) begin miscompares++; $display("FAIL busy_no_issue: got %h expected 0", mem_bus); end
      quiet_cycle();
      #1;
      vectors++;
      if (mem_bus !== 70'h0) begin miscompares++; $display("FAIL busy_pending: got %h expected 0", mem_bus); end
      quiet_cycle();
      mem_respValid = 1;
      #1;
      vectors++;
      if (resp_bus !== 2'b01 || mem_reqValid !== 1'b0) begin
         miscompares++; $display("FAIL busy_lsu_resp: resp %b req %b expected 01/0", resp_bus, mem_reqValid);
      end
      quiet_cycle();
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h300, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL busy_ifu_issue: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h300, 32'h0, 4'h0});
      end
      quiet_cycle();
      mem_respValid = 1;
      #1;
      vectors++;
      if (resp_bus !== 2'b10) begin miscompares++; $display("FAIL busy_ifu_resp: got %b expected 10", resp_bus); end
   endtask

   task automatic test_idle_resp();
      quiet_cycle();
      mem_respValid = 1; mem_rdata = 32'hCAFE;
      #1;
      vectors++;
      if (resp_bus !== 2'b00 || rdata !== 32'hCAFE) begin
         miscompares++; $display("FAIL idle_resp_ignored: resp %b rdata %h expected 00/0000cafe", resp_bus, rdata);
      end
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h44;
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h44, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL idle_still_idle: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h44, 32'h0, 4'h0});
      end
      quiet_cycle();
      mem_respValid = 1;
      #1;
      vectors++;
      if (resp_bus !== 2'b10) begin miscompares++; $display("FAIL idle_followup_resp: got %b expected 10", resp_bus); end
   endtask

   task automatic test_reset_busy();
      quiet_cycle();
      lsu_reqValid = 1; lsu_wen = 1; lsu_addr = 32'h88; lsu_wdata = 32'h1; lsu_wmask = 4'h3;
      quiet_cycle();
      reset = 1;
      #1;
      vectors++;
      if (mem_bus !== 70'h0 || resp_bus !== 2'b00) begin
         miscompares++; $display("FAIL rstbusy_outputs: mem %h resp %b expected 0/00", mem_bus, resp_bus);
      end
      quiet_cycle();
      reset = 0;
      mem_respValid = 1; mem_rdata = 32'hBAD;
      #1;
      vectors++;
      if (mem_bus !== 70'h0 || resp_bus !== 2'b00) begin
         miscompares++; $display("FAIL rstbusy_stale_resp: mem %h resp %b expected 0/00", mem_bus, resp_bus);
      end
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h9C;
      #1;
      vectors++;
      if (mem_bus !== {1'b1, 1'b0, 32'h9C, 32'h0, 4'h0}) begin
         miscompares++; $display("FAIL rstbusy_idle_after: got %h expected %h", mem_bus, {1'b1, 1'b0, 32'h9C, 32'h0, 4'h0});
      end
      quiet_cycle();
      mem_respValid = 1;
      #1;
      vectors++;
      if (resp_bus !== 2'b10) begin miscompares++; $display("FAIL rstbusy_followup_resp: got %b expected 10", resp_bus); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ia, la;
      for (int k = 0; k < 4; k++) begin
         ia = $urandom; la = $urandom;
         quiet_cycle();
         ifu_reqValid = 1; ifu_addr = ia; lsu_reqValid = 1; lsu_wen = 0; lsu_addr = la;
         #1;
         vectors++;
         if (mem_bus !== {1'b1, 1'b0, la, 32'h0, 4'h0}) begin
            miscompares++; $display("FAIL pair%0d_lsu_grant: got %h expected %h", k, mem_bus, {1'b1, 1'b0, la, 32'h0, 4'h0});
         end
         quiet_cycle();
         mem_respValid = 1;
         quiet_cycle();
         #1;
         vectors++;
         if (mem_bus !== {1'b1, 1'b0, ia, 32'h0, 4'h0}) begin
            miscompares++; $display("FAIL pair%0d_ifu_grant: got %h expected %h", k, mem_bus, {1'b1, 1'b0, ia, 32'h0, 4'h0});
         end
         quiet_cycle();
         mem_respValid = 1;
      end
      // A lone LSU grant followed by a tie: round-robin favours IFU, fixed priority keeps LSU.
      quiet_cycle();
      lsu_reqValid = 1; lsu_addr = 32'h10;
      quiet_cycle();
      mem_respValid = 1;
      quiet_cycle();
      ifu_reqValid = 1; ifu_addr = 32'h20; lsu_reqValid = 1; lsu_addr = 32'h30;
      #1;
      vectors++;
`ifdef MEM_ARB_RR_EN
      if (mem_addr !== 32'h20) begin miscompares++; $display("FAIL tie_after_lsu: addr %h expected 00000020", mem_addr); end
`else
      if (mem_addr !== 32'h30) begin miscompares++; $display("FAIL tie_after_lsu: addr %h expected 00000030", mem_addr); end
`endif
      for (int i = 0; i < 2; i++) begin
         quiet_cycle();
         mem_respValid = 1;
         quiet_cycle();
      end
      quiet_cycle();
   endtask

   task automatic test_random();
      req_t ifu_q[$];
      req_t lsu_q[$];
      req_t r, exp_req;
      bit   busy = 0;
      bit   own_lsu = 0;
      bit   last_lsu = 0;
      int   wait_cnt = 0;
      bit   ic, lc, win_lsu, issue, exp_ifu_resp, exp_lsu_resp;
      for (int cyc = 0; cyc < 400; cyc++) begin
         quiet_cycle();
         if (ifu_q.size() == 0 && !(busy && !own_lsu) && ($urandom % 3 == 0)) begin
            r.wen = 0; r.addr = $urandom; r.wdata = 0; r.wmask = 0;
            ifu_reqValid = 1; ifu_addr = r.addr;
            ifu_q.push_back(r);
         end
         if (lsu_q.size() == 0 && !(busy && own_lsu) && ($urandom % 3 == 0)) begin
            r.wen = $urandom; r.addr = $urandom; r.wdata = $urandom; r.wmask = $urandom;
            lsu_reqValid = 1; lsu_wen = r.wen; lsu_addr = r.addr; lsu_wdata = r.wdata; lsu_wmask = r.wmask;
            lsu_q.push_back(r);
         end
         mem_rdata = $urandom;
         mem_respValid = busy ? (wait_cnt == 0) : ($urandom % 8 == 0);
         #1;
         ic = !busy && ifu_q.size() != 0;
         lc = !busy && lsu_q.size() != 0;
`ifdef MEM_ARB_RR_EN
         win_lsu = lc && (!ic || !last_lsu);
`else
         win_lsu = lc;
`endif
         issue = ic || lc;
         exp_req = win_lsu ? (lc ? lsu_q[0] : r) : (ic ? ifu_q[0] : r);
         if (!win_lsu) begin exp_req.wen = 0; exp_req.wdata = 0; exp_req.wmask = 0; end
         if (!issue) begin exp_req.wen = 0; exp_req.addr = 0; exp_req.wdata = 0; exp_req.wmask = 0; end
         vectors++;
         if (mem_bus !== {issue, exp_req.wen, exp_req.addr, exp_req.wdata, exp_req.wmask}) begin
            miscompares++;
            $display("FAIL rand_req cyc %0d: got %h expected %h", cyc, mem_bus, {issue, exp_req.wen, exp_req.addr, exp_req.wdata, exp_req.wmask});
         end
         exp_ifu_resp = busy && mem_respValid && !own_lsu;
         exp_lsu_resp = busy && mem_respValid && own_lsu;
         vectors++;
         if (resp_bus !== {exp_ifu_resp, exp_lsu_resp} || rdata !== mem_rdata) begin
            miscompares++;
            $display("FAIL rand_resp cyc %0d: resp %b rdata %h expected %b/%h", cyc, resp_bus, rdata, {exp_ifu_resp, exp_lsu_resp}, mem_rdata);
         end
         if (busy && mem_respValid) busy = 0;
         else if (busy) wait_cnt--;
         if (issue) begin
            if (win_lsu) void'(lsu_q.pop_front());
            else void'(ifu_q.pop_front());
            busy = 1; own_lsu = win_lsu; last_lsu = win_lsu;
            wait_cnt = $urandom % 4;
         end
      end
   endtask

   initial begin
      reset = 1;
      ifu_reqValid = 0; ifu_addr = 0;
      lsu_reqValid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
      mem_respValid = 0; mem_rdata = 0;
      test_reset();
      test_ifu_fetch();
      test_simultaneous();
      test_busy_capture();
      test_idle_resp();
      test_reset_busy();
      test_back_to_back();
      // Fresh reset so the random model starts from an empty, idle, IFU-last arbiter.
      test_reset();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
